// File: rtl/light_display_pkg.sv
// Shared types and segment constants for the scanned traffic display.
// Imported by light_display_scan and bcd_to_seg.
package light_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    typedef logic [1:0] dig_idx_t;

    localparam dig_idx_t IDX_FIRST = 2'd0;
    localparam dig_idx_t IDX_LAST  = 2'd3;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry n holds the {g,f,e,d,c,b,a} pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic       a_light;
        logic       b_light;
        logic [3:0] b_time_h;
        logic [3:0] b_time_l;
        logic [3:0] a_time_h;
        logic [3:0] a_time_l;
    } snapshot_t;

    function automatic logic [3:0] digit_of(input snapshot_t snap, input dig_idx_t idx);
        logic [3:0] d;
        case (idx)
            2'd0:    d = snap.a_time_l;
            2'd1:    d = snap.a_time_h;
            2'd2:    d = snap.b_time_l;
            2'd3:    d = snap.b_time_h;
            default: d = snap.a_time_l;
        endcase
        return d;
    endfunction

    function automatic logic is_fault(input snapshot_t snap);
        return snap.a_light & snap.b_light;
    endfunction

    function automatic logic time_is_low(input logic [3:0] hi, input logic [3:0] lo);
        return (hi == 4'd0) && (lo <= 4'd3);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; codes 10..15 render as a dash.
module bcd_to_seg
    import light_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup for valid digits, dash for everything else
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_TABLE[0];
            4'd1:    seg = SEG_TABLE[1];
            4'd2:    seg = SEG_TABLE[2];
            4'd3:    seg = SEG_TABLE[3];
            4'd4:    seg = SEG_TABLE[4];
            4'd5:    seg = SEG_TABLE[5];
            4'd6:    seg = SEG_TABLE[6];
            4'd7:    seg = SEG_TABLE[7];
            4'd8:    seg = SEG_TABLE[8];
            4'd9:    seg = SEG_TABLE[9];
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/light_display_scan.sv
// Scanned 4-digit 7-segment display and lamp driver fed by the traffic controller.
// Optional blinking of low countdowns is enabled with `define LIGHT_DISPLAY_BLINK_EN.
module light_display_scan
    import light_display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       A_Light,
    input  logic       B_Light,
    input  logic [3:0] A_Time_L,
    input  logic [3:0] A_Time_H,
    input  logic [3:0] B_Time_L,
    input  logic [3:0] B_Time_H,
    output logic [6:0] Seg,
    output logic [3:0] Dig_En,
    output logic       A_Green,
    output logic       A_Red,
    output logic       B_Green,
    output logic       B_Red
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SCAN_END  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);

    state_t           state_r, state_n_s;
    logic [CNT_W-1:0] presc_r, presc_n_s;
    dig_idx_t         idx_r, idx_n_s;
    snapshot_t        snap_r, snap_n_s, live_s;
    logic             first_load_s, frame_wrap_s;

    logic [6:0]       seg_r, seg_n_s, dec_seg_s;
    logic [3:0]       dig_en_r, dig_en_n_s;
    logic [3:0]       lamps_r, lamps_n_s;
    logic [3:0]       digit_s;
    logic             fault_s, dir_low_s, blink_off_s;

    assign live_s = '{a_light:  A_Light,  b_light:  B_Light,
                      b_time_h: B_Time_H, b_time_l: B_Time_L,
                      a_time_h: A_Time_H, a_time_l: A_Time_L};

    // Scan sequencer: prescaler, digit index and once-per-frame snapshot
    always_comb begin
        state_n_s    = state_r;
        presc_n_s    = presc_r + CNT_W'(1);
        idx_n_s      = idx_r;
        first_load_s = 1'b0;
        frame_wrap_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (presc_r == SCAN_END) begin
                    state_n_s    = ST_SHOW;
                    presc_n_s    = '0;
                    idx_n_s      = IDX_FIRST;
                    first_load_s = 1'b1;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_SHOW: begin
                if (presc_r == SCAN_END) begin
                    state_n_s = ST_BLANK;
                    presc_n_s = '0;
                end else begin
                    state_n_s = ST_SHOW;
                end
            end
            ST_BLANK: begin
                if (presc_r == BLANK_END) begin
                    state_n_s    = ST_SHOW;
                    presc_n_s    = '0;
                    idx_n_s      = idx_r + 2'd1;
                    frame_wrap_s = (idx_r == IDX_LAST);
                end else begin
                    state_n_s = ST_BLANK;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                presc_n_s = '0;
                idx_n_s   = IDX_FIRST;
            end
        endcase
    end

    // Snapshot is only refreshed at a frame boundary so a frame never tears
    always_comb begin
        snap_n_s = snap_r;
        if (first_load_s || frame_wrap_s) begin
            snap_n_s = live_s;
        end else begin
            snap_n_s = snap_r;
        end
    end

`ifdef LIGHT_DISPLAY_BLINK_EN
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FRM_W-1:0] FRM_END = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frame_cnt_r, frame_cnt_n_s;
    logic             phase_r, phase_n_s;

    // Blink phase flips after every BLINK_FRAMES completed frames
    always_comb begin
        frame_cnt_n_s = frame_cnt_r;
        phase_n_s     = phase_r;
        if (frame_wrap_s) begin
            if (frame_cnt_r == FRM_END) begin
                frame_cnt_n_s = '0;
                phase_n_s     = ~phase_r;
            end else begin
                frame_cnt_n_s = frame_cnt_r + FRM_W'(1);
            end
        end else begin
            frame_cnt_n_s = frame_cnt_r;
        end
    end

    // Blink state registers; phase starts ON
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_cnt_r <= '0;
            phase_r     <= 1'b1;
        end else begin
            frame_cnt_r <= frame_cnt_n_s;
            phase_r     <= phase_n_s;
        end
    end

    assign blink_off_s = ~phase_n_s;
`else
    assign blink_off_s = 1'b0;
`endif

    assign digit_s = digit_of(snap_n_s, idx_n_s);
    assign fault_s = is_fault(snap_n_s);
    // idx bit1 selects direction B, bit0 selects the tens digit
    assign dir_low_s = idx_n_s[1] ? time_is_low(snap_n_s.b_time_h, snap_n_s.b_time_l)
                                  : time_is_low(snap_n_s.a_time_h, snap_n_s.a_time_l);

    bcd_to_seg u_dec (
        .bcd (digit_s),
        .seg (dec_seg_s)
    );

    // Next-cycle display and lamp values, computed from next state so outputs stay registered
    always_comb begin
        seg_n_s    = SEG_BLANK;
        dig_en_n_s = 4'b0000;
        lamps_n_s  = 4'b0000;
        if (state_n_s == ST_SHOW) begin
            dig_en_n_s = 4'b0001 << idx_n_s;
            if (fault_s) begin
                seg_n_s = SEG_DASH;
            end else if (blink_off_s && dir_low_s) begin
                seg_n_s = SEG_BLANK;
            end else if (idx_n_s[0] && (digit_s == 4'd0)) begin
                seg_n_s = SEG_BLANK;
            end else begin
                seg_n_s = dec_seg_s;
            end
        end else begin
            dig_en_n_s = 4'b0000;
            seg_n_s    = SEG_BLANK;
        end
        if (state_n_s == ST_IDLE) begin
            lamps_n_s = 4'b0000;
        end else if (fault_s) begin
            lamps_n_s = 4'b0101;
        end else begin
            lamps_n_s = {snap_n_s.a_light, ~snap_n_s.a_light,
                         snap_n_s.b_light, ~snap_n_s.b_light};
        end
    end

    // State, snapshot and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            presc_r  <= '0;
            idx_r    <= IDX_FIRST;
            snap_r   <= '0;
            seg_r    <= SEG_BLANK;
            dig_en_r <= 4'b0000;
            lamps_r  <= 4'b0000;
        end else begin
            state_r  <= state_n_s;
            presc_r  <= presc_n_s;
            idx_r    <= idx_n_s;
            snap_r   <= snap_n_s;
            seg_r    <= seg_n_s;
            dig_en_r <= dig_en_n_s;
            lamps_r  <= lamps_n_s;
        end
    end

    assign Seg     = seg_r;
    assign Dig_En  = dig_en_r;
    assign A_Green = lamps_r[3];
    assign A_Red   = lamps_r[2];
    assign B_Green = lamps_r[1];
    assign B_Red   = lamps_r[0];

endmodule

// File: tb/tb_light_display_scan.sv
// Directed scoreboard bench for light_display_scan (SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2).
module tb_light_display_scan;

    localparam int SCAN  = 4;
    localparam int BLANK = 1;
    localparam int BLINK = 2;

    // Lamp vectors as {A_Green, A_Red, B_Green, B_Red}
    localparam logic [3:0] L_AG = 4'b1001;
    localparam logic [3:0] L_FT = 4'b0101;
    localparam logic [3:0] L_BG = 4'b0110;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       A_Light, B_Light;
    logic [3:0] A_Time_L, A_Time_H, B_Time_L, B_Time_H;
    logic [6:0] Seg;
    logic [3:0] Dig_En;
    logic       A_Green, A_Red, B_Green, B_Red;
    logic [3:0] lamps;

    typedef struct packed {
        logic [3:0] en;
        logic [6:0] seg;
        logic [3:0] lamps;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    light_display_scan #(
        .SCAN_DIV     (SCAN),
        .BLANK_CYCLES (BLANK),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .A_Light  (A_Light),
        .B_Light  (B_Light),
        .A_Time_L (A_Time_L),
        .A_Time_H (A_Time_H),
        .B_Time_L (B_Time_L),
        .B_Time_H (B_Time_H),
        .Seg      (Seg),
        .Dig_En   (Dig_En),
        .A_Green  (A_Green),
        .A_Red    (A_Red),
        .B_Green  (B_Green),
        .B_Red    (B_Red)
    );

    assign lamps = {A_Green, A_Red, B_Green, B_Red};

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] en, input logic [6:0] seg, input logic [3:0] lmp);
        exp_q.push_back(exp_t'({en, seg, lmp}));
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] lmp);
        push(4'b0001, s0, lmp);
        push(4'b0010, s1, lmp);
        push(4'b0100, s2, lmp);
        push(4'b1000, s3, lmp);
    endtask

    task automatic pop(output exp_t e);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed 0 entries expected 1");
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic show_cycle(input string tag, input exp_t e);
        @(negedge Clk);
        chk(tag, {17'd0, Dig_En, Seg, lamps}, {17'd0, e});
    endtask

    task automatic check_digit(input string tag);
        exp_t e;
        pop(e);
        for (int c = 0; c < SCAN; c++) show_cycle($sformatf("%s_show%0d", tag, c), e);
        for (int c = 0; c < BLANK; c++) begin
            @(negedge Clk);
            chk($sformatf("%s_blank", tag), {21'd0, Dig_En, Seg}, 32'd0);
            chk($sformatf("%s_blank_lamps", tag), {28'd0, lamps}, {28'd0, e.lamps});
        end
    endtask

    task automatic check_frame(input string tag);
        for (int d = 0; d < 4; d++) check_digit($sformatf("%s_d%0d", tag, d));
    endtask

    // Release reset at a falling edge and check the dark IDLE interval
    task automatic release_and_idle(input string tag);
        Reset = 1'b0;
        chk({tag, "_idle0"}, {21'd0, Dig_En, Seg, lamps}, 32'd0);
        for (int c = 1; c < SCAN; c++) begin
            @(negedge Clk);
            chk($sformatf("%s_idle%0d", tag, c), {17'd0, Dig_En, Seg, lamps}, 32'd0);
        end
    endtask

    initial begin
        A_Light = 1'b1; B_Light = 1'b0;
        A_Time_H = 4'd2; A_Time_L = 4'd5;
        B_Time_H = 4'd0; B_Time_L = 4'd7;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("reset_outputs", {17'd0, Dig_En, Seg, lamps}, 32'd0);

        // Frame 1: A=25, B=07, A green
        push_frame(7'h6D, 7'h5B, 7'h07, 7'h00, L_AG);
        release_and_idle("f1");
        check_digit("f1_d0");
        // Mid-frame edits must wait for the next snapshot
        A_Time_L = 4'd4; B_Time_L = 4'd8;
        push_frame(7'h66, 7'h5B, 7'h7F, 7'h00, L_AG);
        check_digit("f1_d1");
        check_digit("f1_d2");
        check_digit("f1_d3");

        // Frame 2: A=24, B=08; then invalid tens digit on A
        check_digit("f2_d0");
        A_Time_H = 4'd12;
        push_frame(7'h66, 7'h40, 7'h7F, 7'h00, L_AG);
        check_digit("f2_d1");
        check_digit("f2_d2");
        check_digit("f2_d3");

        // Frame 3: A tens invalid; then both lights green (fault)
        check_digit("f3_d0");
        B_Light = 1'b1;
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, L_FT);
        check_digit("f3_d1");
        check_digit("f3_d2");
        check_digit("f3_d3");

        // Frame 4: fault display; then a legal pair with B green
        check_digit("f4_d0");
        A_Light = 1'b0; A_Time_H = 4'd1;
        push(4'b0001, 7'h66, L_BG);
        push(4'b0010, 7'h06, L_BG);
        push(4'b0100, 7'h7F, L_BG);
        check_digit("f4_d1");
        check_digit("f4_d2");
        check_digit("f4_d3");

        // Frame 5: fault cleared; reset lands during digit 2
        check_digit("f5_d0");
        check_digit("f5_d1");
        begin
            exp_t e;
            pop(e);
            show_cycle("f5_d2_show0", e);
        end
        Reset = 1'b1;
        #1;
        chk("midframe_reset", {17'd0, Dig_En, Seg, lamps}, 32'd0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        A_Light = 1'b1; B_Light = 1'b0;
        A_Time_H = 4'd2; A_Time_L = 4'd5;
        B_Time_H = 4'd0; B_Time_L = 4'd7;
        repeat (2) @(negedge Clk);
        chk("reset_hold", {17'd0, Dig_En, Seg, lamps}, 32'd0);

        // Restart must match the first frame exactly
        push_frame(7'h6D, 7'h5B, 7'h07, 7'h00, L_AG);
        release_and_idle("r1");
        check_frame("r1");

`ifdef LIGHT_DISPLAY_BLINK_EN
        // Blink: B=03 blanks in OFF phase (frames 3,4), A=25 untouched
        Reset = 1'b1;
        B_Time_L = 4'd3;
        repeat (2) @(negedge Clk);
        for (int f = 1; f <= 6; f++) begin
            push_frame(7'h6D, 7'h5B, ((f == 3) || (f == 4)) ? 7'h00 : 7'h4F, 7'h00, L_AG);
        end
        release_and_idle("bk");
        for (int f = 1; f <= 6; f++) check_frame($sformatf("bk_f%0d", f));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
